// File: rtl/gen_reg32_pkg.sv
// Shared constants for the datapath storage registers.
package gen_reg32_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned MAR_ADDR_W = 9;

    localparam logic [WORD_W-1:0] RESET_DEFAULT = WORD_W'(32'h0000_0000);

endpackage : gen_reg32_pkg

// File: rtl/gen_reg32.sv
// Edge-triggered storage register with load enable and asynchronous clear.
// Used for MAR, MDR, PC, IR, HI/LO and the general-purpose register file.
module gen_reg32
    import gen_reg32_pkg::*;
#(
    parameter int                WIDTH       = WORD_W,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (enable) begin
            q_d = D;
        end
    end

    // Clear has priority over load and acts without a clock edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

`ifndef SYNTHESIS
    if (WIDTH < 1) begin : g_width_check
        $error("gen_reg32: WIDTH must be at least 1");
    end

    a_clr_holds_reset : assert property (@(posedge clk) clr |-> (Q == RESET_VALUE));

    // A clr pulse between edges may legitimately move Q during a hold.
    a_hold_stable : assert property (@(posedge clk) disable iff (clr)
        !enable |=> ($stable(Q) || (Q == RESET_VALUE)));
`endif

endmodule : gen_reg32

// File: tb/tb_gen_reg32.sv
// Randomized self-checking bench for gen_reg32 against a rule-level reference model.
module tb_gen_reg32;
    import gen_reg32_pkg::*;

    logic              clk = 1'b0;
    logic              clr;
    logic              enable;
    logic [WORD_W-1:0] D;
    logic [WORD_W-1:0] Q;

    int total = 0;
    int bad   = 0;

    // Reference: what the register should be holding right now.
    logic [WORD_W-1:0] model_q;

    always #5 clk = ~clk;

    gen_reg32 dut (
        .clk    (clk),
        .clr    (clr),
        .enable (enable),
        .D      (D),
        .Q      (Q)
    );

    task automatic check(input string tag, input logic [WORD_W-1:0] got,
                         input logic [WORD_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs 1 time unit after an edge, take one edge, check 1 unit later.
    task automatic cycle(input string tag, input logic c, input logic e,
                         input logic [WORD_W-1:0] d);
        clr    = c;
        enable = e;
        D      = d;
        if (c) model_q = RESET_DEFAULT;
        @(posedge clk);
        if (c)      model_q = RESET_DEFAULT;
        else if (e) model_q = d;
        #1;
        check(tag, Q, model_q);
    endtask

    // Clear pulse entirely between edges; effect must be immediate.
    task automatic pulse_clr(input string tag);
        #1 clr = 1'b1;
        model_q = RESET_DEFAULT;
        #1 check({tag, "_during"}, Q, model_q);
        clr = 1'b0;
        #1 check({tag, "_after"}, Q, model_q);
    endtask

    initial begin
        logic [MAR_ADDR_W-1:0] mar_addr;
        logic [WORD_W-1:0]     plan_d [3];

        clr     = 1'b0;
        enable  = 1'b0;
        D       = '0;
        model_q = 'x;
        #1 clr  = 1'b1;
        model_q = RESET_DEFAULT;
        #1 check("reset_async", Q, model_q);

        // Clear dominates while the clock runs with load requested.
        for (int i = 0; i < 3; i++) cycle("reset_hold", 1'b1, 1'b1, 32'hDEAD_BEEF);

        cycle("load_85", 1'b0, 1'b1, 32'h0000_0085);
        mar_addr = Q[MAR_ADDR_W-1:0];
        check("mar_addr", WORD_W'(mar_addr), 32'h0000_0085);

        for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 1'b0, 32'hFFFF_FFF0);
        cycle("load_fff0", 1'b0, 1'b1, 32'hFFFF_FFF0);

        cycle("load_0f", 1'b0, 1'b1, 32'h0000_000F);
        pulse_clr("midclr");
        cycle("post_clr_hold", 1'b0, 1'b0, 32'hA5A5_A5A5);

        cycle("prio_clr", 1'b1, 1'b1, 32'h1234_5678);
        cycle("prio_release", 1'b0, 1'b1, 32'h1234_5678);

        plan_d[0] = 32'h44;
        plan_d[1] = 32'h35;
        plan_d[2] = 32'h90;
        for (int i = 0; i < 3; i++) cycle("b2b", 1'b0, 1'b1, plan_d[i]);

        // Random mix of loads, holds, held clears and mid-cycle clear pulses.
        for (int i = 0; i < 300; i++) begin
            logic c;
            logic e;
            c = ($urandom_range(0, 9) == 0);
            e = $urandom_range(0, 1) == 1;
            cycle("rand", c, e, $urandom);
            if ($urandom_range(0, 14) == 0) pulse_clr("rand_pulse");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gen_reg32
